// File: rtl/icache_pkg.sv
// Shared constants, FSM encoding and helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int LINE_BYTES     = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int OFFSET_W       = 4;

  typedef enum logic {
    ST_LOOKUP,
    ST_REFILL
  } state_t;

  typedef logic [WORDS_PER_LINE-1:0][31:0] line_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled for port hookup.
interface icache_if #(
  parameter int ADDR_W = 32
);

  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_instr;
  logic              cpu_hit;
  logic              cpu_stall;
  logic              flush;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic [31:0]       mem_data_0;
  logic [31:0]       mem_data_1;
  logic [31:0]       mem_data_2;
  logic [31:0]       mem_data_3;

  // Cache side
  modport slave (
    input  cpu_addr, flush, mem_ready, mem_data_0, mem_data_1, mem_data_2, mem_data_3,
    output cpu_instr, cpu_hit, cpu_stall, mem_req, mem_addr
  );

  // Fetch stage plus instruction memory side
  modport master (
    output cpu_addr, flush, mem_ready, mem_data_0, mem_data_1, mem_data_2, mem_data_3,
    input  cpu_instr, cpu_hit, cpu_stall, mem_req, mem_addr
  );

endinterface

// File: rtl/icache_line_store.sv
// Tag, valid and data arrays of the cache: one combinational read port, one whole-line
// write port and a clear-all for the valid bits. Only the valid bits are reset.
module icache_line_store
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = 3,
  parameter int TAG_W     = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [1:0]       rd_word,
  output logic [31:0]      rd_data,
  output logic [TAG_W-1:0] rd_tag,
  output logic             rd_valid,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  line_t            wr_line,
  input  logic             clr_valid
);

  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  line_t                data_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  // A line write in the same cycle as a clear keeps whatever wr_valid says, so the
  // caller decides whether a concurrent flush wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else begin
      if (clr_valid) valid <= '0;
      if (wr_en) valid[wr_idx] <= wr_valid;
    end
  end

  assign rd_data  = data_q[rd_idx][rd_word];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid[rd_idx];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped instruction cache with whole-block refill from a 4-word memory port.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//
// state     | meaning
// ST_LOOKUP | tag compare on cpu_addr; hit serves the word, miss latches block address
// ST_REFILL | mem_req held until mem_ready, then the latched line is written
module instruction_cache
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int ADDR_W    = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  icache_if.slave     bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int IDX_W = clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       instr_q;
  logic              flush_pending;

  logic [1:0]        word;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [31:0]       rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              lookup_hit;

  logic              hit;
  logic              stall;
  logic              req;
  logic              do_miss;
  logic              fill;
  logic              unused_addr_bits;

  assign word = bus.cpu_addr[3:2];
  assign idx  = bus.cpu_addr[OFFSET_W +: IDX_W];
  assign tag  = bus.cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_idx    (idx),
    .rd_word   (word),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_en     (fill && rst_n),
    .wr_idx    (mem_addr_q[OFFSET_W +: IDX_W]),
    .wr_tag    (mem_addr_q[ADDR_W-1 -: TAG_W]),
    .wr_valid  (!(flush_pending || bus.flush)),
    .wr_line   ({bus.mem_data_3, bus.mem_data_2, bus.mem_data_1, bus.mem_data_0}),
    .clr_valid (bus.flush)
  );

  assign lookup_hit = rd_valid && (rd_tag == tag);

  // A flush in LOOKUP only invalidates; the address is looked up again next cycle.
  always_comb begin
    state_nxt = state;
    hit       = 1'b0;
    stall     = 1'b0;
    req       = 1'b0;
    do_miss   = 1'b0;
    fill      = 1'b0;
    case (state)
      ST_LOOKUP: begin
        hit   = lookup_hit && !bus.flush;
        stall = !hit;
        if (!lookup_hit && !bus.flush) begin
          do_miss   = 1'b1;
          state_nxt = ST_REFILL;
        end
      end
      ST_REFILL: begin
        req   = 1'b1;
        stall = 1'b1;
        if (bus.mem_ready) begin
          fill      = 1'b1;
          state_nxt = ST_LOOKUP;
        end
      end
      default: state_nxt = ST_LOOKUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_LOOKUP;
      mem_addr_q    <= '0;
      instr_q       <= '0;
      flush_pending <= 1'b0;
    end else begin
      state <= state_nxt;
      if (do_miss) mem_addr_q <= {bus.cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
      if (hit) instr_q <= rd_data;
      if (state == ST_REFILL && !fill) flush_pending <= flush_pending || bus.flush;
      else flush_pending <= 1'b0;
    end
  end

  assign bus.cpu_hit   = rst_n && hit;
  assign bus.cpu_stall = rst_n && stall;
  assign bus.cpu_instr = bus.cpu_hit ? rd_data : instr_q;
  assign bus.mem_req   = req;
  assign bus.mem_addr  = mem_addr_q;

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit) hit_cnt <= hit_cnt + 32'd1;
      if (do_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: stimulus queues expected words, fill requests
// and status snapshots; a negedge monitor pops and compares them.
module tb_instruction_cache;

  localparam int ADDR_W  = 32;
  localparam int MEM_LAT = 5;

  typedef struct {
    string       name;
    logic        hit;
    logic        stall;
    logic        req;
    logic        chk_instr;
    logic [31:0] instr;
    logic        chk_maddr;
    logic [31:0] maddr;
    logic        chk_valid;
    logic        chk_stats;
    logic [31:0] hc;
    logic [31:0] mc;
    logic        timeout;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic done = 1'b0;
  logic mem_auto;
  logic flush_on_ready;
  int   mem_cnt;
  int   n_cmp = 0;
  int   n_err = 0;

  st_t         q_st[$];
  logic [31:0] q_instr[$];
  logic [31:0] q_req[$];

  icache_if #(.ADDR_W(ADDR_W)) ifc ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  instruction_cache #(
    .NUM_LINES (8),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic st_t mk(input string name, input logic hit, input logic stall, input logic req);
    st_t s;
    s.name = name;
    s.hit = hit;
    s.stall = stall;
    s.req = req;
    s.chk_instr = 1'b0;
    s.instr = '0;
    s.chk_maddr = 1'b0;
    s.maddr = '0;
    s.chk_valid = 1'b0;
    s.chk_stats = 1'b0;
    s.hc = '0;
    s.mc = '0;
    s.timeout = 1'b0;
    return s;
  endfunction

  // Memory image: each byte holds the low 8 bits of its own address.
  function automatic logic [31:0] blk_word(input logic [31:0] a, input int k);
    logic [7:0] b;
    b = a[7:0] + 8'(4 * k);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ifc.mem_ready = 1'b0;
    ifc.flush = 1'b0;
    if (ifc.mem_req && mem_auto) begin
      if (mem_cnt == MEM_LAT - 1) begin
        ifc.mem_ready  = 1'b1;
        ifc.mem_data_0 = blk_word(ifc.mem_addr, 0);
        ifc.mem_data_1 = blk_word(ifc.mem_addr, 1);
        ifc.mem_data_2 = blk_word(ifc.mem_addr, 2);
        ifc.mem_data_3 = blk_word(ifc.mem_addr, 3);
        mem_cnt = 0;
        if (flush_on_ready) begin
          ifc.flush = 1'b1;
          flush_on_ready = 1'b0;
        end
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
  endtask

  task automatic wait_hit(input string name);
    st_t s;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (ifc.cpu_hit) break;
      tick();
    end
    if (!ifc.cpu_hit) begin
      s = mk(name, 1'b0, 1'b0, 1'b0);
      s.timeout = 1'b1;
      q_st.push_back(s);
    end else begin
      tick();
    end
  endtask

  initial begin : monitor
    logic        req_prev;
    logic [31:0] req_addr;
    st_t         s;
    req_prev = 1'b0;
    req_addr = '0;
    forever begin
      @(negedge clk);
      if (done) break;
      while (q_st.size() > 0) begin
        s = q_st.pop_front();
        if (s.timeout) begin
          n_cmp++;
          n_err++;
          $display("FAIL %s: got no hit within budget, expected a hit", s.name);
        end else begin
          cmp({s.name, ":hit"}, 32'(ifc.cpu_hit), 32'(s.hit));
          cmp({s.name, ":stall"}, 32'(ifc.cpu_stall), 32'(s.stall));
          cmp({s.name, ":mem_req"}, 32'(ifc.mem_req), 32'(s.req));
          if (s.chk_instr) cmp({s.name, ":instr"}, ifc.cpu_instr, s.instr);
          if (s.chk_maddr) cmp({s.name, ":mem_addr"}, ifc.mem_addr, s.maddr);
          if (s.chk_valid) cmp({s.name, ":valid"}, 32'(dut.u_store.valid), 32'h0);
`ifdef ICACHE_STATS_EN
          if (s.chk_stats) begin
            cmp({s.name, ":hit_cnt"}, hit_cnt, s.hc);
            cmp({s.name, ":miss_cnt"}, miss_cnt, s.mc);
          end
`endif
        end
      end
      if (ifc.cpu_hit) begin
        if (q_instr.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_hit: got hit addr %h, expected no hit", ifc.cpu_addr);
        end else begin
          cmp("instr", ifc.cpu_instr, q_instr.pop_front());
        end
      end
      if (ifc.mem_req && !req_prev) begin
        if (q_req.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_req: got mem_req addr %h, expected none", ifc.mem_addr);
        end else begin
          req_addr = q_req.pop_front();
          cmp("mem_addr", ifc.mem_addr, req_addr);
        end
      end else if (ifc.mem_req) begin
        cmp("mem_addr_hold", ifc.mem_addr, req_addr);
      end
      req_prev = ifc.mem_req;
    end
    cmp("leftover_instr", 32'(q_instr.size()), 32'h0);
    cmp("leftover_req", 32'(q_req.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : stim
    st_t s;
    logic [31:0] t2_exp [3];
    t2_exp = '{32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
    ifc.cpu_addr = '0;
    ifc.flush = 1'b0;
    ifc.mem_ready = 1'b0;
    ifc.mem_data_0 = '0;
    ifc.mem_data_1 = '0;
    ifc.mem_data_2 = '0;
    ifc.mem_data_3 = '0;
    mem_auto = 1'b1;
    flush_on_ready = 1'b0;
    mem_cnt = 0;

    rst_n = 1'b0;
    tick();
    tick();
    s = mk("reset", 1'b0, 1'b0, 1'b0);
    s.chk_instr = 1'b1;
    s.chk_maddr = 1'b1;
    s.chk_valid = 1'b1;
    s.chk_stats = 1'b1;
    q_st.push_back(s);
    tick();
    rst_n = 1'b1;

    // Cold miss on 0x00
    q_req.push_back(32'h00);
    q_instr.push_back(32'h03020100);
    q_st.push_back(mk("t1_miss", 1'b0, 1'b1, 1'b0));
    tick();
    s = mk("t1_refill", 1'b0, 1'b1, 1'b1);
    s.chk_maddr = 1'b1;
    s.maddr = 32'h00;
    s.chk_instr = 1'b1;
    s.instr = 32'h0;
    q_st.push_back(s);
    wait_hit("t1_hit");

    // Back-to-back hits in the same line
    for (int i = 0; i < 3; i++) begin
      ifc.cpu_addr = 32'(4 * (i + 1));
      q_instr.push_back(t2_exp[i]);
      q_st.push_back(mk("t2_hit", 1'b1, 1'b0, 1'b0));
      tick();
    end

    // Conflict on index 0
    ifc.cpu_addr = 32'h80;
    q_req.push_back(32'h80);
    q_instr.push_back(32'h83828180);
    wait_hit("t3_hit");
    ifc.cpu_addr = 32'h00;
    q_req.push_back(32'h00);
    q_instr.push_back(32'h03020100);
    wait_hit("t3_back");

    // Address moves while a refill is outstanding
    ifc.cpu_addr = 32'h10;
    q_req.push_back(32'h10);
    tick();
    tick();
    tick();
    ifc.cpu_addr = 32'h20;
    s = mk("t4_hold", 1'b0, 1'b1, 1'b1);
    s.chk_maddr = 1'b1;
    s.maddr = 32'h10;
    q_st.push_back(s);
    q_req.push_back(32'h20);
    q_instr.push_back(32'h23222120);
    wait_hit("t4_new");
    ifc.cpu_addr = 32'h10;
    q_instr.push_back(32'h13121110);
    q_st.push_back(mk("t4_line1", 1'b1, 1'b0, 1'b0));
    tick();

    // Flush coinciding with mem_ready
    ifc.cpu_addr = 32'h30;
    q_req.push_back(32'h30);
    q_req.push_back(32'h30);
    flush_on_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ifc.mem_ready) break;
    end
    if (!ifc.mem_ready) begin
      s = mk("t5_ready", 1'b0, 1'b0, 1'b0);
      s.timeout = 1'b1;
      q_st.push_back(s);
    end
    tick();
    s = mk("t5_flushed", 1'b0, 1'b1, 1'b0);
    s.chk_valid = 1'b1;
    q_st.push_back(s);
    q_instr.push_back(32'h33323130);
    wait_hit("t5_hit");

    // Flush in LOOKUP on a hitting address
    ifc.flush = 1'b1;
    q_st.push_back(mk("lookup_flush", 1'b0, 1'b1, 1'b0));
    tick();
    s = mk("post_flush", 1'b0, 1'b1, 1'b0);
    s.chk_valid = 1'b1;
    q_st.push_back(s);
    q_req.push_back(32'h30);
    q_instr.push_back(32'h33323130);
    wait_hit("refetch");

    // Reset during refill, then stray mem_ready pulses
    ifc.cpu_addr = 32'h40;
    q_req.push_back(32'h40);
    mem_auto = 1'b0;
    s = mk("stats_pre", 1'b0, 1'b1, 1'b0);
    s.chk_stats = 1'b1;
    s.hc = 32'd10;
    s.mc = 32'd8;
    q_st.push_back(s);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    s = mk("t6_reset", 1'b0, 1'b0, 1'b0);
    s.chk_instr = 1'b1;
    s.chk_maddr = 1'b1;
    s.chk_stats = 1'b1;
    q_st.push_back(s);
    ifc.mem_ready = 1'b1;
    ifc.mem_data_0 = 32'hDEADBEEF;
    tick();
    rst_n = 1'b1;
    ifc.mem_ready = 1'b1;
    s = mk("t6_after", 1'b0, 1'b1, 1'b0);
    s.chk_valid = 1'b1;
    q_st.push_back(s);
    mem_auto = 1'b1;
    tick();
    q_req.push_back(32'h40);
    q_instr.push_back(32'h43424140);
    wait_hit("t6_hit");
    ifc.cpu_addr = 32'h00;
    s = mk("final", 1'b0, 1'b1, 1'b0);
    s.chk_stats = 1'b1;
    s.hc = 32'd1;
    s.mc = 32'd1;
    q_st.push_back(s);
    @(negedge clk);
    #1;
    done = 1'b1;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got no summary by 100us, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
